mdr_mem_ctrl: RTL

Parametrised memory data register with a built-in memory handshake controller, replacing the plain bus/memory-mux MDR. It loads from the internal bus or issues req/ack memory reads and writes. Loads are sized (byte/half/word) and sign- or zero-extended; stores drive lane-shifted data with byte enables. It sits between the datapath bus and the memory port; MDRout feeds the bus mux.

---
 rtl/mdr_mem_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mdr_mem_ctrl.sv
// Memory data register with req/ack memory handshake, sized/extended loads and lane-shifted stores.
// Optional ack timeout enabled by defining MDR_TIMEOUT_EN.
module mdr_mem_ctrl #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned OFF_W          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic                    MDRin,
  input  logic                    Read,
  input  logic                    Write,
  input  logic [1:0]              size,
  input  logic                    unsigned_ld,
  input  logic [OFF_W-1:0]        byte_off,
  input  logic [DATA_WIDTH-1:0]   BusMuxOut,
  output logic [DATA_WIDTH-1:0]   MDRout,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ack,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int unsigned NB = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   mdr_d, wdata_d;
  logic                    req_d, we_d, busy_d, done_d, err_d;
  logic [NB-1:0]           be_d;
  logic [1:0]              sz_q, sz_d;
  logic                    uns_q, uns_d;
  logic [OFF_W-1:0]        off_q, off_d;

`ifdef MDR_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

  function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [1:0] s);
    case (s)
      2'b00:   lane_mask = DATA_WIDTH'(8'hFF);
      2'b01:   lane_mask = DATA_WIDTH'(16'hFFFF);
      2'b10:   lane_mask = DATA_WIDTH'(32'hFFFF_FFFF);
      default: lane_mask = '1;
    endcase
  endfunction

  function automatic logic [NB-1:0] be_mask(input logic [1:0] s);
    case (s)
      2'b00:   be_mask = NB'(4'h1);
      2'b01:   be_mask = NB'(4'h3);
      2'b10:   be_mask = NB'(4'hF);
      default: be_mask = '1;
    endcase
  endfunction

  // Natural alignment; dword exists only on a 64-bit memory.
  function automatic logic is_legal(input logic [1:0] s, input logic [OFF_W-1:0] off);
    case (s)
      2'b00:   is_legal = 1'b1;
      2'b01:   is_legal = !off[0];
      2'b10:   is_legal = (off[1:0] == 2'b00);
      default: is_legal = (DATA_WIDTH == 64) && (off == '0);
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] raw,
                                                   input logic [1:0] s, input logic u);
    logic [DATA_WIDTH-1:0] m;
    logic                  sgn;
    m = lane_mask(s);
    case (s)
      2'b00:   sgn = raw[7];
      2'b01:   sgn = raw[15];
      2'b10:   sgn = raw[31];
      default: sgn = raw[DATA_WIDTH-1];
    endcase
    extend = (raw & m) | ((!u && sgn) ? ~m : '0);
  endfunction

  always_comb begin
    state_d = state_q;
    mdr_d   = MDRout;
    req_d   = mem_req;
    we_d    = mem_we;
    be_d    = mem_be;
    wdata_d = mem_wdata;
    busy_d  = busy;
    done_d  = 1'b0;
    err_d   = 1'b0;
    sz_d    = sz_q;
    uns_d   = uns_q;
    off_d   = off_q;
`ifdef MDR_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (Read || Write) begin
          if (!is_legal(size, byte_off)) begin
            err_d = 1'b1;
          end else begin
            req_d  = 1'b1;
            busy_d = 1'b1;
            sz_d   = size;
            uns_d  = unsigned_ld;
            off_d  = byte_off;
`ifdef MDR_TIMEOUT_EN
            cnt_d  = '0;
`endif
            if (Read) begin
              we_d    = 1'b0;
              be_d    = '1;
              state_d = RD_WAIT;
            end else begin
              we_d    = 1'b1;
              be_d    = be_mask(size) << byte_off;
              wdata_d = (MDRout & lane_mask(size)) << {byte_off, 3'b000};
              state_d = WR_WAIT;
            end
          end
        end else if (MDRin) begin
          mdr_d = BusMuxOut;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (mem_ack) begin
          if (state_q == RD_WAIT)
            mdr_d = extend(mem_rdata >> {off_q, 3'b000}, sz_q, uns_q);
          req_d   = 1'b0;
          we_d    = 1'b0;
          be_d    = '0;
          wdata_d = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
`ifdef MDR_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          be_d    = '0;
          wdata_d = '0;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= IDLE;
      MDRout    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      sz_q      <= 2'b00;
      uns_q     <= 1'b0;
      off_q     <= '0;
`ifdef MDR_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      MDRout    <= mdr_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_be    <= be_d;
      mem_wdata <= wdata_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      sz_q      <= sz_d;
      uns_q     <= uns_d;
      off_q     <= off_d;
`ifdef MDR_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

endmodule
